// File: rtl/result_fifo_pkg.sv
// Shared types and constants for the per-block result FIFO and its serial readout.
package terpine_pkg;

    localparam int DATA_W        = 20;
    localparam int META_W        = 16;
    localparam int ENTRY_W       = 36;
    localparam int FRAME_ENTRIES = 5;
    localparam int FRAME_BITS    = 180;

    typedef struct packed {
        logic [15:0] meta;
        logic [19:0] data;
    } result_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } rf_state_t;

    // Even parity: the returned bit makes the XOR over payload plus parity zero.
    function automatic logic even_parity(input logic [34:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/result_fifo_mem.sv
// Simple dual-port result RAM: one write port, one registered read port (1-cycle latency).
module result_fifo_mem
    import terpine_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [ENTRY_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/result_fifo.sv
// Result FIFO with empty/sticky-overflow status and a 180-bit serial frame readout.
// Optional build macro RESULT_FIFO_PARITY_EN replaces bit 35 of each real entry with even parity.
module result_fifo
    import terpine_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [19:0] in_data,
    input  logic [15:0] in_meta,
    input  logic        fifo_req,
    output logic        fifo_empty,
    output logic        fifo_oflow,
    output logic        fifo_bits,
    output logic        busy
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    rf_state_t          r_state;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_count;
    logic [2:0]         r_n;
    logic [2:0]         r_entry;
    logic [5:0]         r_pos;
    logic [34:0]        r_shift;
    logic               r_bits;
    logic               r_busy;
    logic               r_empty;
    logic               r_oflow;

    logic               w_accept;
    logic               w_last_bit;
    logic               w_boundary;
    logic [2:0]         w_next_entry;
    logic               w_pop;
    logic               w_re;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [2:0]         w_n_snap;
    logic [AW:0]        w_count_next;
    logic [ENTRY_W-1:0] w_rdata;
    logic [ENTRY_W-1:0] w_rd_fmt;
    logic [ENTRY_W-1:0] w_entry;
    result_t            w_wr_entry;

    assign w_wr_entry   = '{meta: in_meta, data: in_data};
    assign w_accept     = fifo_req && (r_state == IDLE);
    assign w_last_bit   = (r_state == SHIFT) && (r_entry == 3'd4) && (r_pos == 6'd35);
    assign w_boundary   = (r_state == SHIFT) && (r_pos == 6'd35) && !w_last_bit;
    assign w_next_entry = r_entry + 3'd1;
    // The entry is read one cycle ahead so it can be loaded without a gap.
    assign w_re         = (w_accept && (r_count != '0))
                        || ((r_state == SHIFT) && (r_pos == 6'd34) && (w_next_entry < r_n));
    assign w_pop        = ((r_state == LOAD) && (r_n != 3'd0))
                        || (w_boundary && (w_next_entry < r_n));
    assign w_full       = (r_count == FULL_CNT);
    assign w_push       = in_valid && (!w_full || w_pop);
    assign w_drop       = in_valid && w_full && !w_pop;
    assign w_n_snap     = (r_count >= (AW+1)'(5)) ? 3'd5 : r_count[2:0];

`ifdef RESULT_FIFO_PARITY_EN
    assign w_rd_fmt = {even_parity(w_rdata[34:0]), w_rdata[34:0]};
`else
    assign w_rd_fmt = w_rdata;
`endif

    // Pad entries beyond the snapshotted count serialise as zeros.
    assign w_entry = w_pop ? w_rd_fmt : '0;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + (AW+1)'(1);
            2'b01:   w_count_next = r_count - (AW+1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    result_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_re    (w_re),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_oflow  <= 1'b0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + AW'(1) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? r_rd_ptr + AW'(1) : r_rd_ptr;
            r_count  <= w_count_next;
            r_empty  <= (w_count_next == '0);
            // A drop in the same cycle as an accepted request keeps the flag set.
            if (w_drop) begin
                r_oflow <= 1'b1;
            end else if (w_accept) begin
                r_oflow <= 1'b0;
            end else begin
                r_oflow <= r_oflow;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_n     <= 3'd0;
            r_entry <= 3'd0;
            r_pos   <= 6'd0;
            r_shift <= '0;
            r_bits  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bits <= 1'b0;
                    if (w_accept) begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                        r_n     <= w_n_snap;
                        r_entry <= 3'd0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                LOAD: begin
                    r_state <= SHIFT;
                    r_bits  <= w_entry[0];
                    r_shift <= w_entry[35:1];
                    r_pos   <= 6'd0;
                    r_entry <= 3'd0;
                end
                SHIFT: begin
                    if (w_last_bit) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_bits  <= 1'b0;
                    end else if (r_pos == 6'd35) begin
                        r_bits  <= w_entry[0];
                        r_shift <= w_entry[35:1];
                        r_pos   <= 6'd0;
                        r_entry <= w_next_entry;
                    end else begin
                        r_bits  <= r_shift[0];
                        r_shift <= {1'b0, r_shift[34:1]};
                        r_pos   <= r_pos + 6'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_bits  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_empty = r_empty;
    assign fifo_oflow = r_oflow;
    assign fifo_bits  = r_bits;
    assign busy       = r_busy;

endmodule
